// File: rtl/ex_wb_buffer.sv
// ex_wb_buffer -- two-entry in-order buffer between execute and writeback.
//
// Purpose:
//   Captures execute results (result, destination register, write enable),
//   precomputes the zero/negative flags on capture and presents the oldest
//   entry to writeback. It counts the cycles in which writeback holds the
//   head, saturating at 16'hFFFF. Forwarding to decode is optional.
//
// Configuration:
//   EX_WB_FWD_EN  when defined, fwd_hit/fwd_data return the newest buffered
//                 entry that writes fwd_rs. When undefined, both are tied to
//                 0 and fwd_rs is ignored. All ports exist in both builds.
//
// Ports:
//   clk         clock, all state updates on its rising edge
//   rst         synchronous active-high reset
//   in_valid    execute result offered
//   in_ready    buffer can accept (registered)
//   in_result   shift-unit or ALU result
//   in_rd       destination register
//   in_wen      register write requested
//   out_valid   head entry present
//   out_ready   writeback consumes head
//   out_result  head result
//   out_rd      head destination
//   out_wen     head write enable (forced to 0 when rd == 0)
//   out_zero    head result == 0
//   out_neg     head result bit 31
//   stall_cnt   cycles in which the head was held, saturating
//   fwd_rs      source register queried by decode
//   fwd_hit     forwarding match
//   fwd_data    forwarded value
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on registered state, so a producer may look
// at it before deciding to raise in_valid. The buffer holds out_* stable while
// out_valid=1 and out_ready=0. A producer seeing in_ready=0 keeps its data
// and retries, because the buffer ignores in_valid while FULL.

module ex_wb_buffer (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_result,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_zero,
    output logic        out_neg,
    output logic [15:0] stall_cnt,
    input  logic [4:0]  fwd_rs,
    output logic        fwd_hit,
    output logic [31:0] fwd_data
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wen;
        logic        zero;
        logic        neg;
    } entry_t;

    // head_q is always the oldest entry; tail_q is meaningful only in FULL.
    state_t      state, state_next;
    entry_t      head_q, tail_q;
    entry_t      head_next, tail_next;
    entry_t      new_entry;
    logic        in_ready_q;
    logic [15:0] stall_q;
    logic        push, pop;

    assign out_valid = (state != EMPTY);
    assign in_ready  = in_ready_q;
    assign push      = in_valid && in_ready_q;
    assign pop       = out_valid && out_ready;

    // Register 0 is never written, so its write enable is dropped on capture.
    always_comb begin
        new_entry        = '0;
        new_entry.result = in_result;
        new_entry.rd     = in_rd;
        new_entry.wen    = in_wen && (in_rd != 5'd0);
        new_entry.zero   = (in_result == 32'd0);
        new_entry.neg    = in_result[31];
    end

    always_comb begin
        state_next = state;
        head_next  = head_q;
        tail_next  = tail_q;
        case (state)
            EMPTY: begin
                if (push) begin
                    head_next  = new_entry;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (push && pop) begin
                    // Head leaves and the new entry takes its place.
                    head_next = new_entry;
                end else if (push) begin
                    tail_next  = new_entry;
                    state_next = FULL;
                end else if (pop) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                // in_ready is 0 here, so a push cannot coincide with the pop.
                if (pop) begin
                    head_next  = tail_q;
                    state_next = ONE;
                end
            end
            default: begin
                state_next = EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= EMPTY;
            head_q     <= '0;
            tail_q     <= '0;
            in_ready_q <= 1'b1;
            stall_q    <= 16'd0;
        end else begin
            state      <= state_next;
            head_q     <= head_next;
            tail_q     <= tail_next;
            in_ready_q <= (state_next != FULL);
            if (out_valid && !out_ready && (stall_q != 16'hFFFF)) begin
                stall_q <= stall_q + 16'd1;
            end
        end
    end

    assign out_result = head_q.result;
    assign out_rd     = head_q.rd;
    assign out_wen    = head_q.wen;
    assign out_zero   = head_q.zero;
    assign out_neg    = head_q.neg;
    assign stall_cnt  = stall_q;

`ifdef EX_WB_FWD_EN
    // The tail is newer than the head, so it wins when both match.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = 32'd0;
        if (!rst && (fwd_rs != 5'd0)) begin
            if ((state == FULL) && tail_q.wen && (tail_q.rd == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = tail_q.result;
            end else if ((state != EMPTY) && head_q.wen && (head_q.rd == fwd_rs)) begin
                fwd_hit  = 1'b1;
                fwd_data = head_q.result;
            end
        end
    end
`else
    logic unused_fwd_rs;
    assign unused_fwd_rs = ^fwd_rs;
    assign fwd_hit       = 1'b0;
    assign fwd_data      = 32'd0;
`endif

endmodule

// File: tb/tb_ex_wb_buffer.sv
// tb_ex_wb_buffer -- directed self-checking bench for ex_wb_buffer.
// Inputs change 1 ns after a rising edge. Outputs are sampled at that same
// point, well away from the next active edge.

module tb_ex_wb_buffer;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_rd;
    logic        in_wen;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen;
    logic        out_zero;
    logic        out_neg;
    logic [15:0] stall_cnt;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [31:0] fwd_data;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] exp_q[$];
    logic [31:0] exp_v;

    ex_wb_buffer dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_result  (in_result),
        .in_rd      (in_rd),
        .in_wen     (in_wen),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_wen    (out_wen),
        .out_zero   (out_zero),
        .out_neg    (out_neg),
        .stall_cnt  (stall_cnt),
        .fwd_rs     (fwd_rs),
        .fwd_hit    (fwd_hit),
        .fwd_data   (fwd_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_push(input logic [31:0] res, input logic [4:0] rd, input logic wen);
        in_valid  = 1'b1;
        in_result = res;
        in_rd     = rd;
        in_wen    = wen;
    endtask

    task automatic drive_idle();
        in_valid  = 1'b0;
        in_result = 32'd0;
        in_rd     = 5'd0;
        in_wen    = 1'b0;
    endtask

    // ---------------- checker ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst       = 1'b1;
        out_ready = 1'b0;
        fwd_rs    = 5'd0;
        drive_idle();
        step();
        step();

        // Reset state
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_result", out_result,        32'd0);
        check("rst_out_rd",    {27'd0, out_rd},    32'd0);
        check("rst_out_wen",   {31'd0, out_wen},   32'd0);
        check("rst_out_zero",  {31'd0, out_zero},  32'd0);
        check("rst_out_neg",   {31'd0, out_neg},   32'd0);
        check("rst_stall",     {16'd0, stall_cnt}, 32'd0);
        check("rst_fwd_hit",   {31'd0, fwd_hit},   32'd0);
        check("rst_fwd_data",  fwd_data,           32'd0);

        rst = 1'b0;
        step();

        // Single pass with writeback always ready
        out_ready = 1'b1;
        drive_push(32'h0000_0010, 5'd3, 1'b1);
        step();
        drive_idle();
        check("sp_out_valid", {31'd0, out_valid}, 32'd1);
        check("sp_out_result", out_result,        32'h10);
        check("sp_out_rd",    {27'd0, out_rd},    32'd3);
        check("sp_out_wen",   {31'd0, out_wen},   32'd1);
        check("sp_out_zero",  {31'd0, out_zero},  32'd0);
        check("sp_out_neg",   {31'd0, out_neg},   32'd0);
        check("sp_in_ready",  {31'd0, in_ready},  32'd1);
        step();
        check("sp_drained",   {31'd0, out_valid}, 32'd0);
        check("sp_stall",     {16'd0, stall_cnt}, 32'd0);

        // Backpressure: fill to FULL, hold, then drain in order
        out_ready = 1'b0;
        drive_push(32'hA, 5'd1, 1'b1);
        exp_q.push_back(32'hA);
        step();
        check("bp_one_valid", {31'd0, out_valid}, 32'd1);
        check("bp_one_ready", {31'd0, in_ready},  32'd1);
        check("bp_one_stall", {16'd0, stall_cnt}, 32'd0);
        drive_push(32'hB, 5'd2, 1'b1);
        exp_q.push_back(32'hB);
        step();
        drive_idle();
        check("bp_full_ready", {31'd0, in_ready},  32'd0);
        check("bp_full_head",  out_result,         32'hA);
        check("bp_stall_1",    {16'd0, stall_cnt}, 32'd1);
        step();
        check("bp_stall_2",    {16'd0, stall_cnt}, 32'd2);
        check("bp_head_stable", out_result,        32'hA);
        // A push offered while FULL must be ignored.
        drive_push(32'hC, 5'd9, 1'b1);
        step();
        drive_idle();
        check("bp_stall_3",    {16'd0, stall_cnt}, 32'd3);
        check("bp_ignore_head", out_result,        32'hA);
        check("bp_ignore_rdy", {31'd0, in_ready},  32'd0);
        out_ready = 1'b1;
        exp_v = exp_q.pop_front();
        check("bp_pop_a", out_result, exp_v);
        step();
        exp_v = exp_q.pop_front();
        check("bp_pop_b",      out_result,         exp_v);
        check("bp_pop_b_vld",  {31'd0, out_valid}, 32'd1);
        check("bp_pop_b_rdy",  {31'd0, in_ready},  32'd1);
        check("bp_pop_stall",  {16'd0, stall_cnt}, 32'd3);
        step();
        check("bp_empty",      {31'd0, out_valid}, 32'd0);

        // out_ready in EMPTY has no effect
        step();
        check("empty_pop_vld",   {31'd0, out_valid}, 32'd0);
        check("empty_pop_rdy",   {31'd0, in_ready},  32'd1);
        check("empty_pop_stall", {16'd0, stall_cnt}, 32'd3);

        // Simultaneous push and pop in ONE
        out_ready = 1'b0;
        drive_push(32'h1, 5'd4, 1'b1);
        step();
        check("pp_head1", out_result, 32'h1);
        out_ready = 1'b1;
        drive_push(32'h2, 5'd5, 1'b1);
        step();
        drive_idle();
        check("pp_valid", {31'd0, out_valid}, 32'd1);
        check("pp_head2", out_result,         32'h2);
        check("pp_rd",    {27'd0, out_rd},    32'd5);
        check("pp_ready", {31'd0, in_ready},  32'd1);
        step();
        check("pp_empty", {31'd0, out_valid}, 32'd0);

        // rd=0 drops wen; flags computed on capture
        out_ready = 1'b0;
        drive_push(32'h8000_0000, 5'd0, 1'b1);
        step();
        check("rd0_wen",  {31'd0, out_wen},  32'd0);
        check("rd0_neg",  {31'd0, out_neg},  32'd1);
        check("rd0_zero", {31'd0, out_zero}, 32'd0);
        out_ready = 1'b1;
        drive_push(32'h0, 5'd6, 1'b1);
        step();
        drive_idle();
        check("zero_zero", {31'd0, out_zero}, 32'd1);
        check("zero_neg",  {31'd0, out_neg},  32'd0);
        check("zero_wen",  {31'd0, out_wen},  32'd1);
        step();
        check("zero_empty",  {31'd0, out_valid}, 32'd0);
        check("flags_stall", {16'd0, stall_cnt}, 32'd3);

        // Reset mid-operation in FULL with stall_cnt=5
        out_ready = 1'b0;
        drive_push(32'h55, 5'd8, 1'b1);
        step();
        drive_push(32'h66, 5'd9, 1'b1);
        step();
        drive_idle();
        step();
        check("mid_stall5", {16'd0, stall_cnt}, 32'd5);
        check("mid_full",   {31'd0, in_ready},  32'd0);
        rst       = 1'b1;
        out_ready = 1'b1;
        drive_push(32'h77, 5'd10, 1'b1);
        step();
        check("mid_rst_rdy",    {31'd0, in_ready},  32'd1);
        check("mid_rst_vld",    {31'd0, out_valid}, 32'd0);
        check("mid_rst_stall",  {16'd0, stall_cnt}, 32'd0);
        check("mid_rst_result", out_result,         32'd0);
        rst = 1'b0;
        drive_idle();
        step();
        check("mid_discarded",  {31'd0, out_valid}, 32'd0);

        // Forwarding from the newest matching entry
        out_ready = 1'b0;
        drive_push(32'h11, 5'd7, 1'b1);
        step();
        fwd_rs = 5'd7;
        #1;
`ifdef EX_WB_FWD_EN
        check("fwd_one_hit",  {31'd0, fwd_hit}, 32'd1);
        check("fwd_one_data", fwd_data,         32'h11);
`else
        check("fwd_one_hit",  {31'd0, fwd_hit}, 32'd0);
        check("fwd_one_data", fwd_data,         32'd0);
`endif
        drive_push(32'h22, 5'd7, 1'b1);
        step();
        drive_idle();
`ifdef EX_WB_FWD_EN
        check("fwd_new_hit",  {31'd0, fwd_hit}, 32'd1);
        check("fwd_new_data", fwd_data,         32'h22);
`else
        check("fwd_new_hit",  {31'd0, fwd_hit}, 32'd0);
        check("fwd_new_data", fwd_data,         32'd0);
`endif
        fwd_rs = 5'd0;
        #1;
        check("fwd_rs0_hit",  {31'd0, fwd_hit}, 32'd0);
        check("fwd_rs0_data", fwd_data,         32'd0);
        fwd_rs = 5'd3;
        #1;
        check("fwd_miss_hit", {31'd0, fwd_hit}, 32'd0);
        fwd_rs = 5'd7;

        // stall_cnt saturation: hold the head far beyond 65535 cycles
        for (int i = 0; i < 65540; i++) begin
            step();
        end
        check("sat_stall", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check("sat_head",  out_result,         32'h11);
        out_ready = 1'b1;
        step();
        check("sat_no_wrap", {16'd0, stall_cnt}, 32'h0000_FFFF);
        check("sat_pop_head", out_result,        32'h22);
`ifdef EX_WB_FWD_EN
        check("fwd_after_pop", fwd_data, 32'h22);
`else
        check("fwd_after_pop", fwd_data, 32'd0);
`endif
        step();
        check("final_empty", {31'd0, out_valid}, 32'd0);

        // ---------------- report ----------------
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
